// File: rtl/alu_pkg.sv
// alu_pkg: CU instruction codes, issue FSM state and code classification shared with the IDU.
package alu_pkg;

  localparam int unsigned CODE_W = 6;
  typedef logic [CODE_W-1:0] cu_code_t;

  localparam cu_code_t OP_BEQ   = 6'd4;
  localparam cu_code_t OP_BNE   = 6'd5;
  localparam cu_code_t OP_BLT   = 6'd6;
  localparam cu_code_t OP_BGE   = 6'd7;
  localparam cu_code_t OP_BLTU  = 6'd8;
  localparam cu_code_t OP_BGEU  = 6'd9;
  localparam cu_code_t OP_ADDI  = 6'd18;
  localparam cu_code_t OP_SLTI  = 6'd19;
  localparam cu_code_t OP_SLTIU = 6'd20;
  localparam cu_code_t OP_XORI  = 6'd21;
  localparam cu_code_t OP_ORI   = 6'd22;
  localparam cu_code_t OP_ANDI  = 6'd23;
  localparam cu_code_t OP_SLLI  = 6'd24;
  localparam cu_code_t OP_SRLI  = 6'd25;
  localparam cu_code_t OP_SRAI  = 6'd26;
  localparam cu_code_t OP_ADD   = 6'd27;
  localparam cu_code_t OP_SUB   = 6'd28;
  localparam cu_code_t OP_SLL   = 6'd29;
  localparam cu_code_t OP_SLT   = 6'd30;
  localparam cu_code_t OP_SLTU  = 6'd31;
  localparam cu_code_t OP_XOR   = 6'd32;
  localparam cu_code_t OP_SRL   = 6'd33;
  localparam cu_code_t OP_SRA   = 6'd34;
  localparam cu_code_t OP_OR    = 6'd35;
  localparam cu_code_t OP_AND   = 6'd36;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } issue_state_e;

  function automatic logic is_branch(input cu_code_t code);
    return (code >= OP_BEQ) && (code <= OP_BGEU);
  endfunction

  // SLTIU is decoded by the CU but the ALU has no implementation for it
  function automatic logic is_legal_alu(input cu_code_t code);
    return is_branch(code) || (code == OP_ADDI) || (code == OP_SLTI) ||
           ((code >= OP_XORI) && (code <= OP_AND));
  endfunction

endpackage

// File: rtl/alu_operand_sel.sv
// alu_operand_sel: operand-2 mux, branch-target adder and code legality, all combinational;
// the issue controller registers these at accept.
module alu_operand_sel
  import alu_pkg::*;
(
  input  logic [CODE_W-1:0] instr_i,
  input  logic [31:0]       rs2_i,
  input  logic [31:0]       imm_i,
  input  logic [31:0]       pc_i,
  input  logic              use_imm_i,
  output logic [31:0]       dat2_o,
  output logic [31:0]       br_target_o,
  output logic              legal_o,
  output logic              branch_o
);

  assign dat2_o      = use_imm_i ? imm_i : rs2_i;
  assign br_target_o = pc_i + imm_i;
  assign legal_o     = is_legal_alu(instr_i);
  assign branch_o    = is_branch(instr_i);

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one CU operation to the ALU and returns a registered writeback/branch response.
// Optional ALU_ISSUE_TIMEOUT_EN bounds the wait for ALU_ready to TIMEOUT_CYCLES.
//   state   | meaning
//   ST_IDLE | in_ready=1, waiting for in_valid
//   ST_BUSY | dat_ready=1, operands held until ALU_ready
//   ST_RESP | wb_valid=1 for one cycle
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_instr,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  input  logic        in_use_imm,
  input  logic [4:0]  in_rd,
  output logic [31:0] ALU_dat1,
  output logic [31:0] ALU_dat2,
  output logic [5:0]  Instruction_to_CU,
  output logic        dat_ready,
  input  logic [31:0] ALU_out,
  input  logic        ALU_ready,
  input  logic        ALU_con_met,
  input  logic        ALU_overflow,
  input  logic        ALU_zero,
  input  logic        ALU_err,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        br_valid,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        resp_overflow,
  output logic        resp_zero,
  output logic        resp_err
);

  issue_state_e state_q, state_d;
  logic [31:0] dat1_q, dat1_d, dat2_q, dat2_d, br_target_q, br_target_d, wb_data_q, wb_data_d;
  logic [5:0]  instr_q, instr_d;
  logic [4:0]  rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic        dat_ready_q, dat_ready_d, branch_q, branch_d;
  logic        wb_valid_q, wb_valid_d, wb_we_q, wb_we_d, br_valid_q, br_valid_d;
  logic        br_taken_q, br_taken_d, ovf_q, ovf_d, zero_q, zero_d, err_q, err_d;

  logic [31:0] sel_dat2, sel_target;
  logic        sel_legal, sel_branch;

  alu_operand_sel u_sel (
    .instr_i     (in_instr),
    .rs2_i       (in_rs2),
    .imm_i       (in_imm),
    .pc_i        (in_pc),
    .use_imm_i   (in_use_imm),
    .dat2_o      (sel_dat2),
    .br_target_o (sel_target),
    .legal_o     (sel_legal),
    .branch_o    (sel_branch)
  );

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    dat1_d      = dat1_q;
    dat2_d      = dat2_q;
    instr_d     = instr_q;
    rd_d        = rd_q;
    branch_d    = branch_q;
    br_target_d = br_target_q;
    dat_ready_d = dat_ready_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = wb_we_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    br_valid_d  = br_valid_q;
    br_taken_d  = br_taken_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    err_d       = err_q;
`ifdef ALU_ISSUE_TIMEOUT_EN
    wait_d      = wait_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          rd_d        = in_rd;
          branch_d    = sel_branch;
          br_target_d = sel_target;
          if (sel_legal) begin
            dat1_d      = in_rs1;
            dat2_d      = sel_dat2;
            instr_d     = in_instr;
            dat_ready_d = 1'b1;
            state_d     = ST_BUSY;
`ifdef ALU_ISSUE_TIMEOUT_EN
            wait_d      = '0;
`endif
          end else begin
            // illegal code answers immediately; the ALU-facing registers stay untouched
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_rd_d    = in_rd;
            wb_data_d  = '0;
            br_valid_d = sel_branch;
            br_taken_d = 1'b0;
            ovf_d      = 1'b0;
            zero_d     = 1'b0;
            err_d      = 1'b1;
            state_d    = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        if (ALU_ready) begin
          dat_ready_d = 1'b0;
          wb_valid_d  = 1'b1;
          wb_we_d     = !branch_q && (rd_q != 5'd0) && !ALU_err;
          wb_rd_d     = rd_q;
          wb_data_d   = ALU_out;
          br_valid_d  = branch_q;
          br_taken_d  = branch_q && ALU_con_met;
          ovf_d       = ALU_overflow;
          zero_d      = ALU_zero;
          err_d       = ALU_err;
          state_d     = ST_RESP;
        end
`ifdef ALU_ISSUE_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          dat_ready_d = 1'b0;
          wb_valid_d  = 1'b1;
          wb_we_d     = 1'b0;
          wb_rd_d     = rd_q;
          wb_data_d   = '0;
          br_valid_d  = branch_q;
          br_taken_d  = 1'b0;
          ovf_d       = 1'b0;
          zero_d      = 1'b0;
          err_d       = 1'b1;
          state_d     = ST_RESP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dat1_q      <= '0;
      dat2_q      <= '0;
      instr_q     <= '0;
      rd_q        <= '0;
      branch_q    <= 1'b0;
      br_target_q <= '0;
      dat_ready_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      br_valid_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_ISSUE_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dat1_q      <= dat1_d;
      dat2_q      <= dat2_d;
      instr_q     <= instr_d;
      rd_q        <= rd_d;
      branch_q    <= branch_d;
      br_target_q <= br_target_d;
      dat_ready_q <= dat_ready_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      br_valid_q  <= br_valid_d;
      br_taken_q  <= br_taken_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
`ifdef ALU_ISSUE_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  assign in_ready          = (state_q == ST_IDLE);
  assign ALU_dat1          = dat1_q;
  assign ALU_dat2          = dat2_q;
  assign Instruction_to_CU = instr_q;
  assign dat_ready         = dat_ready_q;
  assign wb_valid          = wb_valid_q;
  assign wb_we             = wb_we_q;
  assign wb_rd             = wb_rd_q;
  assign wb_data           = wb_data_q;
  assign br_valid          = br_valid_q;
  assign br_taken          = br_taken_q;
  assign br_target         = br_target_q;
  assign resp_overflow     = ovf_q;
  assign resp_zero         = zero_q;
  assign resp_err          = err_q;

endmodule
